// File: rtl/viterbi_word_deserializer.sv
// viterbi_word_deserializer
//   Back end of the Viterbi decoder. After a start pulse it skips the decoder's
//   fixed latency, then packs the decoded bit stream MSB-first into WORD_W-bit
//   words. Words are handed out through a 2-entry buffer with valid/ready.
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous reset, active low
//   enb         stage enable; counters, shift register and FSM advance only when 1
//   start       one-cycle pulse marking the first frame bit entering the encoder
//   decoded     decoded bit from the Viterbi decoder
//   word_out    head of the output buffer (holds last value when empty)
//   word_valid  buffer non-empty
//   word_ready  consumer accepts word_out when word_valid && word_ready
//   overflow    sticky: a completed word was dropped because the buffer was full
//   state       FSM state for debug (IDLE=0, SKIP=1, COLLECT=2)
//
// state   | meaning
// IDLE    | waiting for start; decoded is ignored
// SKIP    | counting out the decoder latency
// COLLECT | shifting decoded bits into words, back-to-back
module viterbi_word_deserializer #(
  parameter int WORD_W      = 16,
  parameter int DEC_LATENCY = 32,
  parameter int BUF_DEPTH   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enb,
  input  logic              start,
  input  logic              decoded,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              overflow,
  output logic [1:0]        state
);

  localparam int SKIP_W = (DEC_LATENCY > 1) ? $clog2(DEC_LATENCY) : 1;
  localparam int BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [SKIP_W-1:0] SKIP_LOAD = SKIP_W'(DEC_LATENCY - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);

  if (DEC_LATENCY < 1) begin : g_bad_latency
    $error("viterbi_word_deserializer: DEC_LATENCY must be >= 1");
  end
  if (BUF_DEPTH != 2) begin : g_bad_depth
    $error("viterbi_word_deserializer: BUF_DEPTH must be 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_COLLECT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [SKIP_W-1:0]   skip_cnt_q, skip_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]   sreg_q, sreg_d;
  logic [WORD_W-1:0]   fifo_q [2];
  logic [WORD_W-1:0]   fifo_d [2];
  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic [1:0]          count_q, count_d;
  logic [WORD_W-1:0]   word_out_q, word_out_d;
  logic                word_valid_q, word_valid_d;
  logic                overflow_q, overflow_d;

  logic                beat;
  logic                push;
  logic                pop;
  logic                full;
  logic                accept;
  logic [WORD_W-1:0]   push_word;

  // The cycle on which the skip counter hits zero is already DEC_LATENCY
  // enb-cycles after start, so that cycle samples the first bit while the
  // FSM moves to COLLECT.
  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sreg_d     = sreg_q;
    beat       = 1'b0;
    push       = 1'b0;
    push_word  = {sreg_q[WORD_W-2:0], decoded};
    if (enb) begin
      if (start) begin
        // restart drops any partial word; buffered words are untouched
        state_d    = ST_SKIP;
        skip_cnt_d = SKIP_LOAD;
        bit_cnt_d  = '0;
      end else begin
        case (state_q)
          ST_IDLE: ;
          ST_SKIP: begin
            if (skip_cnt_q == '0) begin
              state_d = ST_COLLECT;
              beat    = 1'b1;
            end else begin
              skip_cnt_d = skip_cnt_q - SKIP_W'(1);
            end
          end
          ST_COLLECT: beat = 1'b1;
          default: state_d = ST_IDLE;
        endcase
      end
      if (beat) begin
        sreg_d = push_word;
        if (bit_cnt_q == BIT_LAST) begin
          push      = 1'b1;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
    end
  end

  // Output buffer. On push+pop while full, the write pointer equals the read
  // pointer, so the new word lands in the slot being vacated by the pop.
  always_comb begin
    pop        = word_valid_q && word_ready;
    full       = (count_q == 2'd2);
    accept     = push && (!full || pop);
    fifo_d     = fifo_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push && full && !pop);
    if (accept) begin
      fifo_d[wr_ptr_q] = push_word;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: ;
    endcase
    word_valid_d = (count_d != 2'd0);
    word_out_d   = word_valid_d ? fifo_d[rd_ptr_d] : word_out_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      skip_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      sreg_q       <= '0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      skip_cnt_q   <= skip_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      sreg_q       <= sreg_d;
      fifo_q       <= fifo_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign overflow   = overflow_q;
  assign state      = state_q;

endmodule

// File: tb/tb_viterbi_word_deserializer.sv
// Testbench for viterbi_word_deserializer: table-driven frames, hand-written
// corner sequences and a random run, all checked every cycle against a
// reference model that counts enb-cycles since start and gathers sampled bits
// into words and a two-word queue.
module tb_viterbi_word_deserializer;

  localparam int DL = 32;
  localparam int W  = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enb = 1'b0;
  logic          start = 1'b0;
  logic          decoded = 1'b0;
  logic          word_ready = 1'b0;
  logic [W-1:0]  word_out;
  logic          word_valid;
  logic          overflow;
  logic [1:0]    state;

  viterbi_word_deserializer #(.WORD_W(W), .DEC_LATENCY(DL), .BUF_DEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .enb        (enb),
    .start      (start),
    .decoded    (decoded),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overflow   (overflow),
    .state      (state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model
  bit            m_active;
  int            m_n;
  logic          m_bits[$];
  logic [W-1:0]  m_q[$];
  logic [W-1:0]  m_out;
  bit            m_ovf;
  logic          tx[$];

  typedef struct {
    logic [W-1:0] w0, w1, w2;
    int nw;
    int sgap;
    int cgap;
    int lat;
  } vec_t;
  vec_t vecs[3];

  function automatic vec_t mk(logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c,
                              int nw, int sg, int cg, int lat);
    vec_t v;
    v.w0 = a; v.w1 = b; v.w2 = c; v.nw = nw; v.sgap = sg; v.cgap = cg; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int m_state();
    if (!m_active) return 0;
    return (m_n < DL) ? 1 : 2;
  endfunction

  task automatic model_step(input logic e, input logic s, input logic d, input logic r);
    bit pop;
    bit push;
    logic [W-1:0] w;
    pop  = (m_q.size() != 0) && r;
    push = 0;
    w    = '0;
    if (e) begin
      if (s) begin
        m_active = 1;
        m_n = 0;
        m_bits.delete();
      end else if (m_active) begin
        m_n++;
        if (m_n >= DL) begin
          m_bits.push_back(d);
          if (m_bits.size() == W) begin
            foreach (m_bits[i]) w = {w[W-2:0], m_bits[i]};
            m_bits.delete();
            push = 1;
          end
        end
      end
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < 2) m_q.push_back(w);
      else m_ovf = 1;
    end
    if (m_q.size() != 0) m_out = m_q[0];
  endtask

  task automatic step(input logic e, input logic s, input logic d, input logic r);
    enb = e; start = s; decoded = d; word_ready = r;
    model_step(e, s, d, r);
    @(posedge clk);
    #1;
    chk("word_valid", 32'(word_valid), 32'(m_q.size() != 0));
    chk("word_out", 32'(word_out), 32'(m_out));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("state", 32'(state), 32'(m_state()));
  endtask

  // supplies the next frame bit on cycles that sample, random data otherwise
  task automatic drive(input logic e, input logic s, input logic r);
    logic d;
    if (e && !s && m_active && (m_n + 1 >= DL) && tx.size() != 0) d = tx.pop_front();
    else d = 1'($urandom);
    step(e, s, d, r);
  endtask

  task automatic load_word(input logic [W-1:0] w);
    for (int b = W - 1; b >= 0; b--) tx.push_back(w[b]);
  endtask

  task automatic do_reset();
    enb = 1'b0; start = 1'b0; word_ready = 1'b0;
    reset = 1'b0;
    #1;
    m_active = 0; m_n = 0; m_bits.delete(); m_q.delete(); m_out = '0; m_ovf = 0;
    tx.delete();
    chk("rst_valid", 32'(word_valid), 32'd0);
    chk("rst_out", 32'(word_out), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int arr[$];
    logic [W-1:0] ws[3];
    logic e;
    ws[0] = v.w0; ws[1] = v.w1; ws[2] = v.w2;
    do_reset();
    for (int i = 0; i < v.nw; i++) load_word(ws[i]);
    drive(1'b1, 1'b1, 1'b1);
    for (int t = 1; t <= 200 && arr.size() < v.nw; t++) begin
      e = 1'b1;
      if (t >= 10 && t < 10 + v.sgap) e = 1'b0;
      if (t >= DL + v.sgap + 5 && t < DL + v.sgap + 5 + v.cgap) e = 1'b0;
      drive(e, 1'b0, 1'b1);
      if (word_valid) begin
        chk("vec_word", 32'(word_out), 32'(ws[arr.size()]));
        arr.push_back(t + 1);
      end
    end
    for (int i = 0; i < v.nw; i++)
      chk("vec_latency", (i < arr.size()) ? 32'(arr[i]) : 32'hFFFF_FFFF, 32'(v.lat + 16 * i));
  endtask

  initial begin
    int cnt;
    int first;
    vecs[0] = mk(16'hA5C3, 16'h0000, 16'h0000, 1, 0, 0, DL + 16);
    vecs[1] = mk(16'h1234, 16'h0000, 16'h0000, 1, 5, 5, DL + 16 + 10);
    vecs[2] = mk(16'h0001, 16'h8000, 16'hFFFF, 3, 0, 0, DL + 16);

    #3;
    for (int i = 0; i < 3; i++) run_vec(vecs[i]);

    // buffer fills, third word overflows, then two pops in order
    do_reset();
    load_word(16'h0001); load_word(16'h8000); load_word(16'hFFFF);
    drive(1'b1, 1'b1, 1'b0);
    for (int t = 1; t <= DL + 47; t++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (t == DL + 46) chk("ovf_before", 32'(overflow), 32'd0);
    end
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(word_out), 32'h0001);
    drive(1'b0, 1'b0, 1'b1);
    chk("pop1_valid", 32'(word_valid), 32'd1);
    chk("pop1_word", 32'(word_out), 32'h8000);
    drive(1'b0, 1'b0, 1'b1);
    chk("pop2_empty", 32'(word_valid), 32'd0);
    chk("pop2_hold", 32'(word_out), 32'h8000);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // restart after 7 collected bits
    do_reset();
    drive(1'b1, 1'b1, 1'b1);
    for (int t = 1; t <= DL + 6; t++) drive(1'b1, 1'b0, 1'b1);
    tx.delete();
    load_word(16'hBEEF);
    drive(1'b1, 1'b1, 1'b1);
    first = -1;
    for (int t = 1; t <= DL + 20; t++) begin
      drive(1'b1, 1'b0, 1'b1);
      if (word_valid && first < 0) begin
        first = t + 1;
        chk("restart_word", 32'(word_out), 32'hBEEF);
      end
    end
    chk("restart_latency", 32'(first), 32'(DL + 16));

    // reset mid-COLLECT with one word buffered and 9 bits in
    do_reset();
    load_word(16'h5A5A);
    drive(1'b1, 1'b1, 1'b0);
    for (int t = 1; t <= DL + 15 + 9; t++) drive(1'b1, 1'b0, 1'b0);
    chk("pre_reset_valid", 32'(word_valid), 32'd1);
    chk("pre_reset_state", 32'(state), 32'd2);
    do_reset();
    cnt = 0;
    for (int t = 0; t < 80; t++) begin
      drive(1'b1, 1'b0, 1'b1);
      if (word_valid) cnt++;
    end
    chk("no_word_after_reset", 32'(cnt), 32'd0);

    // random traffic
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      logic e, s, r;
      e = ($urandom_range(0, 4) != 0);
      s = ($urandom_range(0, 79) == 0);
      r = ($urandom_range(0, 2) != 0);
      drive(e, s, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
